imem_program_loader: RTL and testbench

//  Writer side of the instruction memory read by the fetch stage. Accepts a byte stream
//  (valid/ready), assembles big-endian 16-bit instruction words and writes them to

---
 rtl/imem_program_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_program_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Byte-stream boot loader: assembles big-endian 16-bit words and writes them into instruction memory.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] ADDR_STEP = 16'd4,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold,
    output logic [3:0]  dbg_state_o
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        DONE    = 4'd7,
`ifdef LOADER_CHECKSUM_EN
        CHK     = 4'd6,
`endif
        ERR     = 4'd8
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    state_t      fin_state;
    logic [15:0] count_q, count_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        xfer;
    logic [15:0] len_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    // Handshake: a byte moves on every rising edge where byte_valid && byte_ready;
    // byte_ready depends only on state, never on byte_valid.
    always_comb begin
        byte_ready = 1'b0;
        unique case (state_q)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHK:                              byte_ready = 1'b1;
`endif
            default:                          byte_ready = 1'b0;
        endcase
    end

    assign xfer     = byte_valid & byte_ready;
    assign len_word = {len_hi_q, byte_in};

`ifdef LOADER_CHECKSUM_EN
    assign fin_state = CHK;
`else
    assign fin_state = DONE;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_hi_d = len_hi_q;
        hi_d     = hi_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    addr_d  = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_hi_d = byte_in;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    count_d = len_word;
                    if (len_word == 16'd0) begin
                        state_d = fin_state;
                    end else if ({1'b0, len_word} > MAX_W) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    hi_d    = byte_in;
                    state_d = DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + byte_in;
`endif
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    wdata_d = {hi_q, byte_in};
                    state_d = WRITE;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = sum_q + byte_in;
`endif
                end
            end
            WRITE: begin
                // Address advances only after the strobe cycle, so it is stable while mem_we=1.
                addr_d  = addr_q + ADDR_STEP;
                count_d = count_q - 16'd1;
                state_d = (count_q == 16'd1) ? fin_state : DATA_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_d = ((sum_q + byte_in) == 8'h00) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 16'd0;
            len_hi_q <= 8'h00;
            hi_q     <= 8'h00;
            addr_q   <= BASE_ADDR;
            wdata_q  <= 16'h0000;
            busy_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_hi_q <= len_hi_d;
            hi_q     <= hi_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign mem_we      = (state_q == WRITE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = busy_q;
    assign done        = (state_q == DONE);
    assign error       = (state_q == ERR);
    assign cpu_hold    = (state_q != DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: table of image headers, random images
// against a queue-based write model, plus reset-mid-load and checksum sequences.
module tb_imem_program_loader;

    localparam logic [15:0] BASE = 16'h0000;
    localparam logic [15:0] STEP = 16'd4;
    localparam int          MAXW = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;
    logic [3:0]  dbg_state;

    imem_program_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold),
        .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int writes_seen = 0;
    logic we_prev = 1'b0;
    logic [31:0] exp_q[$];
    logic [15:0] img_q[$];

    typedef struct {
        logic [15:0] hdr;
        logic        exp_done;
        logic        exp_err;
        int          exp_writes;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the head of the expected {addr,data} queue.
    always @(negedge clock) begin
        if (!reset && mem_we) begin
            writes_seen++;
            if (we_prev) begin
                n_tests++;
                n_fail++;
                $display("FAIL we_pulse_width: got 2+ cycles expected 1");
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h@%0h expected none", mem_wdata, mem_addr);
            end else begin
                check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
        we_prev = !reset && mem_we;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
        check({tag, "_mem_addr"},   {16'd0, mem_addr},   {16'd0, BASE});
        check({tag, "_mem_wdata"},  {16'd0, mem_wdata},  32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_error"},      {31'd0, error},      32'd0);
        check({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd1);
        check({tag, "_state_idle"}, {28'd0, dbg_state},  32'd0);
    endtask

    task automatic do_start();
        @(negedge clock);
        byte_valid = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Random idle gaps (with start wiggled, which a busy loader must ignore), then one transfer.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        byte_valid = 1'b0;
        repeat (gap) begin
            start   = 1'($urandom_range(0, 1));
            byte_in = 8'($urandom);
            @(posedge clock);
            #1;
        end
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = b;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clock);
            if (byte_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
            end
        end
        byte_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_timeout: got no ready expected ready for byte %0h", b);
        end
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            if (done || error) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL end_timeout: got no done/error expected one within 50 cycles");
        end
    endtask

    // Loads img_q under header hdr; expectations come from the stream rules, not the DUT.
    task automatic run_image(input logic [15:0] hdr, input int max_gap,
                             output logic got_done, output logic got_err, output int got_writes);
        logic        exp_err;
        logic [15:0] exp_addr;
        logic [7:0]  sum;
        exp_err  = (int'(hdr) > MAXW);
        exp_addr = exp_err ? BASE : 16'(BASE + hdr * STEP);
        sum      = 8'h00;
        exp_q.delete();
        if (!exp_err)
            for (int i = 0; i < int'(hdr); i++) exp_q.push_back({16'(BASE + i * STEP), img_q[i]});
        do_start();
        writes_seen = 0;
        check("start_clears_done", {30'd0, done, error}, 32'd0);
        send_byte(hdr[15:8], max_gap);
        send_byte(hdr[7:0], max_gap);
        if (!exp_err) begin
            for (int i = 0; i < int'(hdr); i++) begin
                logic [15:0] w;
                w = img_q[i];
                send_byte(w[15:8], max_gap);
                send_byte(w[7:0], max_gap);
                sum = sum + w[15:8] + w[7:0];
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(8'h00 - sum, max_gap);
`endif
        end
        wait_end();
        got_done   = done;
        got_err    = error;
        got_writes = writes_seen;
        check("img_done",       {31'd0, done},       {31'd0, !exp_err});
        check("img_error",      {31'd0, error},      {31'd0, exp_err});
        check("img_cpu_hold",   {31'd0, cpu_hold},   {31'd0, exp_err});
        check("img_busy",       {31'd0, busy},       32'd0);
        check("img_ready_low",  {31'd0, byte_ready}, 32'd0);
        check("img_final_addr", {16'd0, mem_addr},   {16'd0, exp_addr});
        check("img_queue_left", exp_q.size(),        32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        logic gd, ge;
        int   gw;
        logic [15:0] n;

        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        #12;
        check_reset_vals("reset");
        @(negedge clock);
        reset = 1'b0;

        vecs[0] = '{16'd2,      1'b1, 1'b0, 2};
        vecs[1] = '{16'd0,      1'b1, 1'b0, 0};
        vecs[2] = '{16'd257,    1'b0, 1'b1, 0};
        vecs[3] = '{16'd256,    1'b1, 1'b0, 256};
        vecs[4] = '{16'd1,      1'b1, 1'b0, 1};
        vecs[5] = '{16'h8000,   1'b0, 1'b1, 0};
        vecs[6] = '{16'd3,      1'b1, 1'b0, 3};

        for (int v = 0; v < 7; v++) begin
            img_q.delete();
            if (vecs[v].hdr == 16'd2) begin
                img_q.push_back(16'h1234);
                img_q.push_back(16'hABCD);
            end else if (int'(vecs[v].hdr) <= MAXW) begin
                for (int i = 0; i < int'(vecs[v].hdr); i++) img_q.push_back(16'($urandom));
            end
            run_image(vecs[v].hdr, (v == 3) ? 0 : 2, gd, ge, gw);
            check($sformatf("vec%0d_done", v),   {31'd0, gd}, {31'd0, vecs[v].exp_done});
            check($sformatf("vec%0d_err", v),    {31'd0, ge}, {31'd0, vecs[v].exp_err});
            check($sformatf("vec%0d_writes", v), gw,          vecs[v].exp_writes);
        end

        // Same image as the first vector, with heavy random byte_valid gaps.
        img_q.delete();
        img_q.push_back(16'h1234);
        img_q.push_back(16'hABCD);
        run_image(16'd2, 6, gd, ge, gw);
        check("gappy_writes", gw, 32'd2);

        // Reset between HI and LO of word 2, then a clean reload.
        exp_q.delete();
        exp_q.push_back({BASE, 16'h1234});
        exp_q.push_back({16'(BASE + STEP), 16'hABCD});
        do_start();
        writes_seen = 0;
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        send_byte(8'hAB, 1);
        #2;
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("midreset");
        check("midreset_writes", writes_seen, 32'd1);
        exp_q.delete();
        reset = 1'b0;
        run_image(16'd2, 1, gd, ge, gw);
        check("reload_writes", gw, 32'd2);

        // Randomised images against the queue model, including oversize headers.
        for (int r = 0; r < 20; r++) begin
            n = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(257, 400)) : 16'($urandom_range(0, 6));
            img_q.delete();
            if (int'(n) <= MAXW)
                for (int i = 0; i < int'(n); i++) img_q.push_back(16'($urandom));
            run_image(n, 3, gd, ge, gw);
            check($sformatf("rand%0d_writes", r), gw, (int'(n) > MAXW) ? 32'd0 : 32'(n));
        end

`ifdef LOADER_CHECKSUM_EN
        // 0x12+0x34 = 0x46; 0x46+0xBA wraps to 0 (good), 0x46+0xBB does not (bad).
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            exp_q.push_back({BASE, 16'h1234});
            do_start();
            send_byte(8'h00, 1);
            send_byte(8'h01, 1);
            send_byte(8'h12, 1);
            send_byte(8'h34, 1);
            send_byte((k == 0) ? 8'hBA : 8'hBB, 1);
            wait_end();
            check($sformatf("chk%0d_done", k),  {31'd0, done},  {31'd0, k == 0});
            check($sformatf("chk%0d_error", k), {31'd0, error}, {31'd0, k == 1});
            check($sformatf("chk%0d_queue", k), exp_q.size(),   32'd0);
        end
`endif

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
